dcache_wb_fsm: RTL and testbench

//  Parametrised master controller for a write-back, write-allocate cache (D-side; also usable as I-side with
//  cpu_op tied 0). Successor to the read-only I-cache master FSM: adds dirty-victim writeback, uncached

---
 rtl/dcache_wb_fsm.sv | 148 ++++++++++++++
 tb/tb_dcache_wb_fsm.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_fsm.sv
// Master controller for a write-back / write-allocate cache: hit pipelining, dirty victim
// writeback, line or single-word refill, uncached accesses and lookup/miss counters.
module dcache_wb_fsm #(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_valid,
  input  logic                          cpu_op,
  input  logic                          cpu_uncached,
  input  logic                          cache_hit,
  input  logic                          victim_dirty,
  input  logic                          rd_rdy,
  input  logic                          ret_valid,
  input  logic                          ret_last,
  input  logic                          wr_rdy,
  output logic                          ram_en,
  output logic                          miss_stall,
  output logic                          rd_req,
  output logic                          rd_type,
  output logic                          wr_req,
  output logic                          wr_type,
  output logic                          refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
  output logic [CNT_W-1:0]              lookup_cnt,
  output logic [CNT_W-1:0]              miss_cnt
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WBACK, S_REPLACE, S_REFILL, S_UNC_WR
  } state_t;

  state_t           r_state, w_next;
  logic             r_rd_type;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_lookup_cnt, r_miss_cnt;

  logic w_ram_en, w_stall, w_rd_req, w_rd_type, w_wr_req, w_wr_type, w_refill_we;
  logic w_type_ld, w_type_val, w_ret_done;

  assign w_ret_done = ret_valid & ret_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rd_type    <= 1'b0;
      r_idx        <= '0;
      r_lookup_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_type_ld)
        r_rd_type <= w_type_val;
      if (r_state == S_LOOKUP)
        r_lookup_cnt <= r_lookup_cnt + CNT_ONE;
      if (r_state == S_REPLACE && rd_rdy)
        r_idx <= '0;
      else if (r_state == S_REFILL && ret_valid)
        r_idx <= r_idx + IDX_ONE;
      // Only full-line refills count as cache misses; uncached loads do not.
      if (r_state == S_REFILL && w_ret_done && r_rd_type)
        r_miss_cnt <= r_miss_cnt + CNT_ONE;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ram_en    = 1'b0;
    w_stall     = 1'b0;
    w_rd_req    = 1'b0;
    w_rd_type   = 1'b0;
    w_wr_req    = 1'b0;
    w_wr_type   = 1'b0;
    w_refill_we = 1'b0;
    w_type_ld   = 1'b0;
    w_type_val  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_valid) begin
          w_ram_en = 1'b1;
          w_next   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (cpu_uncached) begin
          w_stall = 1'b1;
          if (cpu_op) begin
            w_next = S_UNC_WR;
          end else begin
            w_type_ld = 1'b1;
            w_next    = S_REPLACE;
          end
        end else if (!cache_hit) begin
          w_stall    = 1'b1;
          w_type_ld  = 1'b1;
          w_type_val = 1'b1;
          w_next     = victim_dirty ? S_WBACK : S_REPLACE;
        end else if (cpu_valid) begin
          w_ram_en = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WBACK: begin
        w_stall   = 1'b1;
        w_wr_type = 1'b1;
        w_wr_req  = wr_rdy;
        if (wr_rdy) w_next = S_REPLACE;
      end
      S_REPLACE: begin
        w_stall   = 1'b1;
        w_rd_type = r_rd_type;
        w_rd_req  = rd_rdy;
        if (rd_rdy) w_next = S_REFILL;
      end
      S_REFILL: begin
        w_rd_type   = r_rd_type;
        w_refill_we = ret_valid & r_rd_type;
        if (w_ret_done) w_next = S_IDLE;
        else            w_stall = 1'b1;
      end
      S_UNC_WR: begin
        w_wr_req = wr_rdy;
        if (wr_rdy) w_next = S_IDLE;
        else        w_stall = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Mealy outputs are forced low while reset is held, even if inputs are active.
  assign ram_en     = w_ram_en    & ~rst;
  assign miss_stall = w_stall     & ~rst;
  assign rd_req     = w_rd_req    & ~rst;
  assign rd_type    = w_rd_type   & ~rst;
  assign wr_req     = w_wr_req    & ~rst;
  assign wr_type    = w_wr_type   & ~rst;
  assign refill_we  = w_refill_we & ~rst;
  assign refill_idx = r_idx;
  assign lookup_cnt = r_lookup_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_dcache_wb_fsm.sv
// Testbench for dcache_wb_fsm: vector table, directed miss/uncached/reset sequences,
// and randomized traffic against a phase-queue reference model.
module tb_dcache_wb_fsm;

  localparam int LW = 4;

  localparam logic [8:0] I_V    = 9'b100000000;
  localparam logic [8:0] I_OP   = 9'b010000000;
  localparam logic [8:0] I_UNC  = 9'b001000000;
  localparam logic [8:0] I_HIT  = 9'b000100000;
  localparam logic [8:0] I_DRT  = 9'b000010000;
  localparam logic [8:0] I_RRDY = 9'b000001000;
  localparam logic [8:0] I_RV   = 9'b000000100;
  localparam logic [8:0] I_RL   = 9'b000000010;
  localparam logic [8:0] I_WRDY = 9'b000000001;

  localparam int PH_WB = 1, PH_RD = 2, PH_RET = 3, PH_UWR = 4;

  logic clk, rst;
  logic cpu_valid, cpu_op, cpu_uncached, cache_hit, victim_dirty;
  logic rd_rdy, ret_valid, ret_last, wr_rdy;
  logic ram_en, miss_stall, rd_req, rd_type, wr_req, wr_type, refill_we;
  logic [1:0]  refill_idx;
  logic [31:0] lookup_cnt, miss_cnt;
  logic [6:0]  dut_o;

  int errors = 0;
  int checks = 0;

  dcache_wb_fsm #(.LINE_WORDS(LW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_op(cpu_op),
    .cpu_uncached(cpu_uncached), .cache_hit(cache_hit), .victim_dirty(victim_dirty),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .wr_rdy(wr_rdy),
    .ram_en(ram_en), .miss_stall(miss_stall), .rd_req(rd_req), .rd_type(rd_type),
    .wr_req(wr_req), .wr_type(wr_type), .refill_we(refill_we), .refill_idx(refill_idx),
    .lookup_cnt(lookup_cnt), .miss_cnt(miss_cnt)
  );

  assign dut_o = {ram_en, miss_stall, rd_req, rd_type, wr_req, wr_type, refill_we};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference model: an outstanding-work queue of bus phases plus a lookup flag.
  int          q[$];
  bit          m_look, m_line;
  int          m_idx;
  logic [31:0] m_lk, m_ms;

  task automatic model_step(output logic [6:0] e, output int eidx,
                            output logic [31:0] elk, output logic [31:0] ems);
    logic re, st, rq, rt, wq, wt, we;
    {re, st, rq, rt, wq, wt, we} = 7'b0;
    eidx = m_idx; elk = m_lk; ems = m_ms;
    if (rst) begin
      q.delete();
      m_look = 0; m_line = 0; m_idx = 0; m_lk = 0; m_ms = 0;
      eidx = 0; elk = 0; ems = 0;
    end else if (q.size() != 0) begin
      case (q[0])
        PH_WB: begin
          st = 1; wt = 1; wq = wr_rdy;
          if (wr_rdy) void'(q.pop_front());
        end
        PH_RD: begin
          st = 1; rt = m_line; rq = rd_rdy;
          if (rd_rdy) begin void'(q.pop_front()); m_idx = 0; end
        end
        PH_RET: begin
          rt = m_line; we = ret_valid & m_line;
          st = !(ret_valid & ret_last);
          if (ret_valid) m_idx = (m_idx + 1) % LW;
          if (ret_valid & ret_last) begin
            void'(q.pop_front());
            if (m_line) m_ms = m_ms + 1;
          end
        end
        default: begin
          wq = wr_rdy; st = !wr_rdy;
          if (wr_rdy) void'(q.pop_front());
        end
      endcase
    end else if (m_look) begin
      m_lk = m_lk + 1;
      if (cpu_uncached) begin
        st = 1; m_look = 0;
        if (cpu_op) q.push_back(PH_UWR);
        else begin m_line = 0; q.push_back(PH_RD); q.push_back(PH_RET); end
      end else if (!cache_hit) begin
        st = 1; m_look = 0; m_line = 1;
        if (victim_dirty) q.push_back(PH_WB);
        q.push_back(PH_RD); q.push_back(PH_RET);
      end else if (cpu_valid) re = 1;
      else m_look = 0;
    end else if (cpu_valid) begin
      re = 1; m_look = 1;
    end
    e = {re, st, rq, rt, wq, wt, we};
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [8:0] in);
    {cpu_valid, cpu_op, cpu_uncached, cache_hit, victim_dirty,
     rd_rdy, ret_valid, ret_last, wr_rdy} = in;
  endtask

  task automatic settle(input string tag);
    logic [6:0]  e;
    int          ei;
    logic [31:0] el, em;
    #3;
    model_step(e, ei, el, em);
    chk({tag, "_outs"}, 64'(dut_o), 64'(e));
    chk({tag, "_idx"}, 64'(refill_idx), 64'(ei));
    chk({tag, "_lkcnt"}, 64'(lookup_cnt), 64'(el));
    chk({tag, "_mscnt"}, 64'(miss_cnt), 64'(em));
  endtask

  task automatic edge_t();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag);
    settle(tag);
    edge_t();
  endtask

  typedef struct {
    logic [8:0] in;
    logic [6:0] exp;
    int         idx;
    int         lk;
    int         ms;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // outputs: {ram_en, miss_stall, rd_req, rd_type, wr_req, wr_type, refill_we}
    tbl[0]  = '{I_V,          7'b1000000, 0, 0, 0};
    tbl[1]  = '{I_V | I_HIT,  7'b1000000, 0, 0, 0};
    tbl[2]  = '{I_V | I_HIT,  7'b1000000, 0, 1, 0};
    tbl[3]  = '{I_HIT,        7'b0000000, 0, 2, 0};
    tbl[4]  = '{I_V,          7'b1000000, 0, 3, 0};
    tbl[5]  = '{I_V,          7'b0100000, 0, 3, 0};
    tbl[6]  = '{9'b0,         7'b0101000, 0, 4, 0};
    tbl[7]  = '{9'b0,         7'b0101000, 0, 4, 0};
    tbl[8]  = '{I_RRDY,       7'b0111000, 0, 4, 0};
    tbl[9]  = '{I_RV,         7'b0101001, 0, 4, 0};
    tbl[10] = '{9'b0,         7'b0101000, 1, 4, 0};
    tbl[11] = '{I_RV,         7'b0101001, 1, 4, 0};
    tbl[12] = '{I_RV,         7'b0101001, 2, 4, 0};
    tbl[13] = '{I_RV | I_RL,  7'b0001001, 3, 4, 0};
    tbl[14] = '{9'b0,         7'b0000000, 0, 4, 1};

    rst = 1'b1;
    drive(I_V | I_RRDY | I_WRDY);
    for (int i = 0; i < 2; i++) begin
      settle("reset");
      chk("reset_outs_zero", 64'(dut_o), 64'd0);
      edge_t();
    end
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].in);
      settle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_outs", i), 64'(dut_o), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_idx", i), 64'(refill_idx), 64'(tbl[i].idx));
      chk($sformatf("tbl%0d_lkcnt", i), 64'(lookup_cnt), 64'(tbl[i].lk));
      chk($sformatf("tbl%0d_mscnt", i), 64'(miss_cnt), 64'(tbl[i].ms));
      edge_t();
    end

    // dirty miss: writeback must complete before the line read is issued
    drive(I_V);         cyc("t4_idle");
    drive(I_V | I_DRT); cyc("t4_lookup");
    for (int i = 0; i < 3; i++) begin
      drive(9'b0); settle("t4_wbwait");
      chk("t4_no_wr_req", 64'(wr_req), 64'd0);
      chk("t4_wb_stall", 64'(miss_stall), 64'd1);
      edge_t();
    end
    drive(I_WRDY); settle("t4_wb");
    chk("t4_wr_req", 64'(wr_req), 64'd1);
    chk("t4_wr_type", 64'(wr_type), 64'd1);
    chk("t4_no_rd_yet", 64'(rd_req), 64'd0);
    edge_t();
    drive(9'b0);   cyc("t4_rdwait");
    drive(I_RRDY); settle("t4_rd");
    chk("t4_rd_req", 64'(rd_req), 64'd1);
    chk("t4_rd_type", 64'(rd_type), 64'd1);
    edge_t();
    for (int i = 0; i < 4; i++) begin
      drive(i == 3 ? (I_RV | I_RL) : I_RV); settle("t4_beat");
      chk("t4_beat_stall", 64'(miss_stall), (i == 3) ? 64'd0 : 64'd1);
      chk("t4_beat_idx", 64'(refill_idx), 64'(i));
      edge_t();
    end
    drive(9'b0); settle("t4_end");
    chk("t4_miss_cnt", 64'(miss_cnt), 64'd2);
    edge_t();

    // uncached load: single-word read, no RAM write, not a miss
    drive(I_V);                 cyc("t5_idle");
    drive(I_V | I_UNC | I_HIT); settle("t5_lookup");
    chk("t5_stall", 64'(miss_stall), 64'd1);
    edge_t();
    drive(I_RRDY); settle("t5_rd");
    chk("t5_rd_req", 64'(rd_req), 64'd1);
    chk("t5_rd_type", 64'(rd_type), 64'd0);
    edge_t();
    drive(I_RV | I_RL); settle("t5_ret");
    chk("t5_no_we", 64'(refill_we), 64'd0);
    chk("t5_unstall", 64'(miss_stall), 64'd0);
    edge_t();
    drive(9'b0); settle("t5_end");
    chk("t5_miss_cnt", 64'(miss_cnt), 64'd2);
    edge_t();

    // uncached store: single-word write then straight back to idle
    drive(I_V);                cyc("t6_idle");
    drive(I_V | I_UNC | I_OP); cyc("t6_lookup");
    drive(9'b0); settle("t6_wait");
    chk("t6_no_wr_req", 64'(wr_req), 64'd0);
    chk("t6_stall", 64'(miss_stall), 64'd1);
    edge_t();
    drive(I_WRDY); settle("t6_wr");
    chk("t6_wr_req", 64'(wr_req), 64'd1);
    chk("t6_wr_type", 64'(wr_type), 64'd0);
    chk("t6_no_rd_req", 64'(rd_req), 64'd0);
    chk("t6_unstall", 64'(miss_stall), 64'd0);
    edge_t();
    drive(I_V); settle("t6_back_idle");
    chk("t6_idle_accept", 64'(ram_en), 64'd1);
    edge_t();
    drive(I_HIT); cyc("t6_hit_exit");

    // reset asserted in the middle of a writeback
    drive(I_V);         cyc("t1a_idle");
    drive(I_V | I_DRT); cyc("t1a_lookup");
    drive(9'b0);        cyc("t1a_wb");
    rst = 1'b1;
    drive(I_V | I_WRDY | I_RRDY); settle("t1a_rst");
    chk("t1a_outs_zero", 64'(dut_o), 64'd0);
    chk("t1a_lk_zero", 64'(lookup_cnt), 64'd0);
    edge_t();
    rst = 1'b0;
    drive(I_V); settle("t1a_after");
    chk("t1a_idle_accept", 64'(ram_en), 64'd1);
    edge_t();
    drive(I_HIT); cyc("t1a_exit");

    // reset asserted mid-refill with a nonzero beat index
    drive(I_V);    cyc("t1b_idle");
    drive(I_V);    cyc("t1b_lookup");
    drive(I_RRDY); cyc("t1b_rd");
    drive(I_RV);   cyc("t1b_b0");
    drive(I_RV);   cyc("t1b_b1");
    rst = 1'b1;
    drive(I_RV); settle("t1b_rst");
    chk("t1b_idx_zero", 64'(refill_idx), 64'd0);
    chk("t1b_ms_zero", 64'(miss_cnt), 64'd0);
    edge_t();
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      logic [8:0] r;
      rst = ($urandom_range(0, 299) == 0);
      r[8] = ($urandom_range(0, 9) < 7);
      r[7] = $urandom_range(0, 1);
      r[6] = ($urandom_range(0, 9) < 2);
      r[5] = ($urandom_range(0, 9) < 6);
      r[4] = $urandom_range(0, 1);
      r[3] = ($urandom_range(0, 9) < 4);
      r[2] = ($urandom_range(0, 9) < 6);
      r[1] = ($urandom_range(0, 9) < 3);
      r[0] = ($urandom_range(0, 9) < 4);
      drive(r);
      cyc("rnd");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
